unidad_fetch: RTL

UNIDAD_FETCH -- requirements
Module: unidad_fetch

---
 rtl/unidad_fetch.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/unidad_fetch.sv
// -----------------------------------------------------------------------------
// unidad_fetch -- instruction fetch unit
//
// Issues word-aligned reads to instruction memory (at most one outstanding),
// buffers returned words with their addresses in a 2-entry FIFO, and presents
// the head instruction together with its address +4 / +8 to the decoder.
// A redirect (PCSrc) flushes the FIFO and reloads the fetch PC. A response
// belonging to a request made before the redirect is discarded.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   PCSrc      in   1   redirect request (taken branch / PC write)
//   Result     in  32   redirect target, bits [1:0] forced to 00
//   IReady     in   1   consumer takes Instr this cycle
//   ImemReq    out  1   memory read request (one cycle per request)
//   ImemAddr   out 32   fetch address, valid while ImemReq=1
//   ImemValid  in   1   read data returned (in order, >=1 cycle later)
//   ImemData   in  32   returned instruction word
//   Instr      out 32   head instruction
//   InstrValid out  1   Instr / PCPlus4 / PCPlus8 valid
//   PCPlus4    out 32   head address + 4
//   PCPlus8    out 32   head address + 8
//
// Configuration
//   FETCH_BYPASS_EN  when defined, a response arriving while the FIFO is
//                    empty is presented on Instr in the same cycle and is
//                    only written to the FIFO if it is not consumed.
// -----------------------------------------------------------------------------
module unidad_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        IReady,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCPlus8
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_instr_d [2];
    logic [31:0] fifo_addr_q  [2];
    logic [31:0] fifo_addr_d  [2];

    logic        req;
    logic        byp;
    logic        push;
    logic        pop;
    logic        in_flight;
    logic [31:0] head_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            req_addr_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_addr_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_addr_q  <= fifo_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fifo_instr_d = fifo_instr_q;
        fifo_addr_d  = fifo_addr_q;

        // Only issue when the FIFO can absorb the response.
        req = (state_q == S_FETCH) && (count_q != 2'd2);

`ifdef FETCH_BYPASS_EN
        byp = (count_q == 2'd0) && (state_q == S_WAIT) && ImemValid && !PCSrc;
`else
        byp = 1'b0;
`endif

        InstrValid = (count_q != 2'd0) || byp;
        Instr      = byp ? ImemData   : fifo_instr_q[rd_ptr_q];
        head_addr  = byp ? req_addr_q : fifo_addr_q[rd_ptr_q];
        PCPlus4    = head_addr + 32'd4;
        PCPlus8    = head_addr + 32'd8;
        ImemReq    = req && !reset;
        ImemAddr   = pc_q;

        // A bypassed word that is consumed never enters the FIFO.
        pop  = InstrValid && IReady && !byp;
        push = (state_q == S_WAIT) && ImemValid && !(byp && IReady);

        // A request is still pending after this edge if we are waiting and no
        // data came back, or if a new request goes out this very cycle.
        in_flight = ((state_q != S_FETCH) && !ImemValid) || req;

        case (state_q)
            S_FETCH: begin
                if (req) begin
                    req_addr_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT, S_DROP: begin
                if (ImemValid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (push) begin
            fifo_instr_d[wr_ptr_q] = ImemData;
            fifo_addr_d[wr_ptr_q]  = req_addr_q;
            wr_ptr_d               = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);

        // Redirect overrides push/pop/request of the same cycle; anything still
        // in flight is routed to DROP so its data is thrown away.
        if (PCSrc) begin
            pc_d     = Result & 32'hFFFF_FFFC;
            count_d  = '0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            state_d  = in_flight ? S_DROP : S_FETCH;
        end
    end

endmodule
